// File: rtl/potential_update_controller.sv
// potential_update_controller: scans all neurons once per timestep. For each
// neuron it hands the stored weight and (optionally decayed) potential to an
// external adder, captures the result, and reports any resulting spike.
// Optional feature macro: POTENTIAL_DECAY_EN (exponent-shift decay in ISSUE).
module potential_update_controller #(
  parameter int unsigned NEURONS     = 16,
  parameter int unsigned DECAY_SHIFT = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       timestep_start,
  input  logic                       weight_valid,
  output logic                       weight_ready,
  input  logic [$clog2(NEURONS)-1:0] weight_addr,
  input  logic [31:0]                weight_value,
  output logic [31:0]                adder_weight,
  output logic [31:0]                adder_potential,
  input  logic [31:0]                adder_result,
  input  logic                       adder_spike,
  output logic                       spike_valid,
  input  logic                       spike_ready,
  output logic [$clog2(NEURONS)-1:0] spike_id,
  output logic                       done
);

  localparam int unsigned IdxW = $clog2(NEURONS);

`ifdef POTENTIAL_DECAY_EN
  localparam bit DecayEn = 1'b1;
`else
  localparam bit DecayEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_EMIT,
    ST_FINISH
  } state_t;

  state_t            r_state;
  logic [IdxW-1:0]   r_idx;
  logic [31:0]       r_potential [NEURONS];
  logic [31:0]       r_weight    [NEURONS];
  logic [31:0]       r_adder_weight;
  logic [31:0]       r_adder_potential;
  logic              r_weight_ready;
  logic              r_spike_valid;
  logic [IdxW-1:0]   r_spike_id;
  logic              r_done;
  logic              w_last;

  // Exponent-field decay: underflow to +0.0, Inf/NaN untouched.
  function automatic logic [31:0] f_decay(input logic [31:0] x);
    logic [7:0] e;
    e = x[30:23];
    if (e <= 8'(DECAY_SHIFT))
      return 32'h0;
    else if (e == 8'hFF)
      return x;
    else
      return {x[31], 8'(e - 8'(DECAY_SHIFT)), x[22:0]};
  endfunction

  // Last neuron of the scan reached.
  assign w_last = (r_idx == IdxW'(NEURONS - 1));

  // Scan FSM, neuron arrays and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state           <= ST_IDLE;
      r_idx             <= '0;
      r_adder_weight    <= 32'h0;
      r_adder_potential <= 32'h0;
      r_weight_ready    <= 1'b1;
      r_spike_valid     <= 1'b0;
      r_spike_id        <= '0;
      r_done            <= 1'b0;
      for (int i = 0; i < int'(NEURONS); i++) begin
        r_potential[i] <= 32'h0;
        r_weight[i]    <= 32'h0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (weight_valid && r_weight_ready)
            r_weight[weight_addr] <= weight_value;
          if (timestep_start) begin
            r_idx          <= '0;
            r_weight_ready <= 1'b0;
            r_state        <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_adder_weight    <= r_weight[r_idx];
          r_adder_potential <= DecayEn ? f_decay(r_potential[r_idx])
                                       : r_potential[r_idx];
          r_state           <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          r_potential[r_idx] <= adder_result;
          r_weight[r_idx]    <= 32'h0;
          if (adder_spike) begin
            r_spike_valid <= 1'b1;
            r_spike_id    <= r_idx;
            r_state       <= ST_EMIT;
          end else if (w_last) begin
            r_state <= ST_FINISH;
          end else begin
            r_idx   <= r_idx + IdxW'(1);
            r_state <= ST_ISSUE;
          end
        end
        ST_EMIT: begin
          if (spike_ready) begin
            r_spike_valid <= 1'b0;
            if (w_last) begin
              r_state <= ST_FINISH;
            end else begin
              r_idx   <= r_idx + IdxW'(1);
              r_state <= ST_ISSUE;
            end
          end
        end
        ST_FINISH: begin
          r_done         <= 1'b1;
          r_weight_ready <= 1'b1;
          r_state        <= ST_IDLE;
        end
        default: begin
          r_weight_ready <= 1'b1;
          r_state        <= ST_IDLE;
        end
      endcase
    end
  end

  assign weight_ready    = r_weight_ready;
  assign adder_weight    = r_adder_weight;
  assign adder_potential = r_adder_potential;
  assign spike_valid     = r_spike_valid;
  assign spike_id        = r_spike_id;
  assign done            = r_done;

endmodule

// File: tb/tb_potential_update_controller.sv
// Bench for potential_update_controller: integer-add adder model, per-neuron
// reference arrays, randomized weights, spike back-pressure and bus noise.
module tb_potential_update_controller;

  localparam int unsigned N  = 16;
  localparam int unsigned IW = 4;
  localparam int unsigned DS = 1;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          timestep_start = 1'b0;
  logic          weight_valid = 1'b0;
  logic          weight_ready;
  logic [IW-1:0] weight_addr = '0;
  logic [31:0]   weight_value = 32'h0;
  logic [31:0]   adder_weight;
  logic [31:0]   adder_potential;
  logic [31:0]   adder_result;
  logic          adder_spike;
  logic          spike_valid;
  logic          spike_ready = 1'b0;
  logic [IW-1:0] spike_id;
  logic          done;

  potential_update_controller #(.NEURONS(N), .DECAY_SHIFT(DS)) dut (
    .clk             (clk),
    .reset           (reset),
    .timestep_start  (timestep_start),
    .weight_valid    (weight_valid),
    .weight_ready    (weight_ready),
    .weight_addr     (weight_addr),
    .weight_value    (weight_value),
    .adder_weight    (adder_weight),
    .adder_potential (adder_potential),
    .adder_result    (adder_result),
    .adder_spike     (adder_spike),
    .spike_valid     (spike_valid),
    .spike_ready     (spike_ready),
    .spike_id        (spike_id),
    .done            (done)
  );

  always #5 clk = ~clk;

  // External adder stand-in: plain 32-bit sum, spikes when low bits are 101.
  assign adder_result = adder_weight + adder_potential;
  assign adder_spike  = (adder_result[2:0] == 3'b101);

  logic [31:0] m_pot [N];
  logic [31:0] m_wgt [N];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_apply(input logic [31:0] x);
`ifdef POTENTIAL_DECAY_EN
    int e;
    e = int'(x[30:23]);
    if (e <= int'(DS)) return 32'h0;
    if (e == 255) return x;
    return {x[31], 8'(e - int'(DS)), x[22:0]};
`else
    return x;
`endif
  endfunction

  function automatic bit m_spike(input logic [31:0] v);
    return (v[2:0] == 3'b101);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < int'(N); i++) begin
      m_pot[i] = 32'h0;
      m_wgt[i] = 32'h0;
    end
  endtask

  task automatic idle_inputs();
    weight_valid   = 1'b0;
    timestep_start = 1'b0;
    spike_ready    = 1'b0;
  endtask

  // Noise on the write port and start line while the scan is busy.
  task automatic junk();
    check_eq("wready_busy", 32'(weight_ready), 32'h0);
    weight_valid   = 1'($urandom_range(0, 1));
    weight_addr    = IW'($urandom);
    weight_value   = $urandom;
    timestep_start = ($urandom_range(0, 3) == 0);
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b1;
    tick();
    check_eq("rst_wready", 32'(weight_ready), 32'h1);
    check_eq("rst_svalid", 32'(spike_valid), 32'h0);
    check_eq("rst_sid", 32'(spike_id), 32'h0);
    check_eq("rst_done", 32'(done), 32'h0);
    check_eq("rst_aw", adder_weight, 32'h0);
    check_eq("rst_ap", adder_potential, 32'h0);
    reset = 1'b0;
    model_clear();
  endtask

  task automatic write_w(input int addr, input logic [31:0] val);
    check_eq("wready_idle", 32'(weight_ready), 32'h1);
    weight_valid = 1'b1;
    weight_addr  = IW'(addr);
    weight_value = val;
    tick();
    weight_valid = 1'b0;
    m_wgt[addr]  = val;
  endtask

  // One full timestep; abort_idx >= 0 resets while that neuron's spike is pending.
  task automatic run_ts(input int abort_idx, input int first_hold);
    int cyc, exp_cyc, hold;
    bit first;
    logic [31:0] exp_p, newp;
    first = 1'b1;
    cyc = 0;
    exp_cyc = 2 * int'(N) + 1;
    timestep_start = 1'b1;
    tick();
    for (int k = 0; k < int'(N); k++) begin
      junk();
      tick(); cyc++;
      exp_p = m_apply(m_pot[k]);
      check_eq($sformatf("aw[%0d]", k), adder_weight, m_wgt[k]);
      check_eq($sformatf("ap[%0d]", k), adder_potential, exp_p);
      check_eq("done_busy", 32'(done), 32'h0);
      newp = m_wgt[k] + exp_p;
      m_pot[k] = newp;
      m_wgt[k] = 32'h0;
      junk();
      tick(); cyc++;
      if (m_spike(newp)) begin
        check_eq("svalid", 32'(spike_valid), 32'h1);
        check_eq("sid", 32'(spike_id), 32'(k));
        if (k == abort_idx) begin
          idle_inputs();
          reset = 1'b1;
          tick();
          reset = 1'b0;
          model_clear();
          check_eq("abort_svalid", 32'(spike_valid), 32'h0);
          check_eq("abort_done", 32'(done), 32'h0);
          check_eq("abort_wready", 32'(weight_ready), 32'h1);
          for (int j = 0; j < 4; j++) begin
            tick();
            check_eq("abort_nodone", 32'(done), 32'h0);
          end
          return;
        end
        hold = (first && first_hold >= 0) ? first_hold : int'($urandom_range(0, 3));
        first = 1'b0;
        for (int h = 0; h < hold; h++) begin
          junk();
          spike_ready = 1'b0;
          tick(); cyc++;
          check_eq("svalid_hold", 32'(spike_valid), 32'h1);
          check_eq("sid_hold", 32'(spike_id), 32'(k));
        end
        junk();
        spike_ready = 1'b1;
        tick(); cyc++;
        spike_ready = 1'b0;
        check_eq("svalid_xfer", 32'(spike_valid), 32'h0);
        exp_cyc += hold + 1;
      end else begin
        check_eq("svalid_none", 32'(spike_valid), 32'h0);
      end
    end
    junk();
    tick(); cyc++;
    idle_inputs();
    check_eq("done", 32'(done), 32'h1);
    check_eq("latency", 32'(cyc), 32'(exp_cyc));
    check_eq("wready_end", 32'(weight_ready), 32'h1);
    tick();
    check_eq("done_pulse", 32'(done), 32'h0);
    tick();
    check_eq("done_single", 32'(done), 32'h0);
  endtask

  initial begin
    model_clear();
    do_reset();

    // Directed timestep: last-write-wins, spike at 7 with 4-cycle back-pressure,
    // decay corner values, and a write coinciding with timestep_start.
    write_w(3, 32'h12345678);
    write_w(3, 32'h41000000);
    write_w(5, 32'h41000000);
    write_w(7, 32'h00000005);
    write_w(8, 32'h00800000);
    write_w(9, 32'h7FC00000);
    weight_valid = 1'b1;
    weight_addr  = IW'(10);
    weight_value = 32'h3F800000;
    m_wgt[10]    = 32'h3F800000;
    run_ts(-1, 4);

    // Zero-weight timestep exposes stored (decayed) potentials.
    run_ts(-1, -1);

    // Randomized timesteps.
    for (int t = 0; t < 5; t++) begin
      for (int w = 0; w < int'($urandom_range(0, 10)); w++)
        write_w(int'($urandom_range(0, N - 1)), $urandom);
      run_ts(-1, -1);
    end

    // Reset while spike of neuron 2 is pending.
    do_reset();
    write_w(2, 32'h00000005);
    run_ts(2, -1);

    // Everything must be cleared: no spikes, 2N+1 latency.
    run_ts(-1, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/potential_update_controller.md
POTENTIAL_UPDATE_CONTROLLER -- requirements
Module: potential_update_controller

Interface
REQ-001 SHALL have parameter NEURONS, default 16, number of neurons scanned per timestep (power of 2, 2..256).
REQ-002 SHALL have parameter DECAY_SHIFT, default 1, decay factor 2^-DECAY_SHIFT applied per timestep (1..8).
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port timestep_start  input  1  one-cycle pulse starting a scan of all neurons.
REQ-006 SHALL have ports weight_valid/weight_ready  input/output  1/1  weight-write handshake.
REQ-007 SHALL have ports weight_addr/weight_value  input  log2(NEURONS)/32  target neuron and IEEE-754 single weight.
REQ-008 SHALL have ports adder_weight/adder_potential  output  32/32  registered operands driven to the external potential adder.
REQ-009 SHALL have ports adder_result/adder_spike  input  32/1  combinational final potential and spike returned by the adder.
REQ-010 SHALL have ports spike_valid/spike_ready/spike_id  output/input/output  1/1/log2(NEURONS)  spike event handshake.
REQ-011 SHALL have port done  output  1  one-cycle pulse when the scan completes.

Function
REQ-012 SHALL hold per-neuron 32-bit potential and weight arrays, both +0.0 (32'h0) after reset.
REQ-013 SHALL implement FSM IDLE, ISSUE, CAPTURE, EMIT, FINISH.
REQ-014 IDLE: weight_ready=1; weight_valid&weight_ready writes weight[weight_addr]; repeated writes to one address -> last wins.
REQ-015 IDLE + timestep_start -> ISSUE with index 0; a simultaneous weight write SHALL complete before the scan reads it.
REQ-016 ISSUE: register adder_weight=weight[idx], adder_potential=decay(potential[idx]) -> CAPTURE next cycle.
REQ-017 CAPTURE: write potential[idx]=adder_result, clear weight[idx] to 32'h0; adder_spike=1 -> EMIT, else advance.
REQ-018 EMIT: spike_valid=1, spike_id=idx held stable until spike_ready; transfer on valid&ready, then advance.
REQ-019 Advance: idx<NEURONS-1 -> idx+1, ISSUE; idx=NEURONS-1 -> FINISH.
REQ-020 FINISH: done=1 for exactly one cycle -> IDLE.
REQ-021 Scan latency without spikes SHALL be 2*NEURONS+1 cycles from timestep_start to done; each spike adds >=1 cycle.
REQ-022 weight_ready SHALL be 0 in every state except IDLE.
REQ-023 timestep_start outside IDLE SHALL be ignored (no queuing).
REQ-024 decay(x): exponent field e; e<=DECAY_SHIFT -> +0.0; e=255 (Inf/NaN) -> unchanged; else e-DECAY_SHIFT, sign and mantissa kept.

Reset
REQ-025 reset SHALL force FSM to IDLE, idx=0, both arrays to 32'h0, adder_weight=adder_potential=0, spike_valid=0, spike_id=0, done=0, weight_ready=1 on the following cycle.
REQ-026 reset mid-scan or mid-EMIT SHALL abort without a done pulse and drop any pending spike.

Configuration
REQ-027 Macro POTENTIAL_DECAY_EN SHALL, when defined, apply decay() per REQ-024 in ISSUE.
REQ-028 Without POTENTIAL_DECAY_EN, adder_potential SHALL equal potential[idx] unchanged and DECAY_SHIFT SHALL be unused.

Verification
REQ-029 Reset, write weight[3]=32'h41000000, timestep_start, adder modelled as add -> potential[3]=32'h41000000, no spike, done at cycle 33 (NEURONS=16).
REQ-030 potential[5]=32'h41000000, weight 0, POTENTIAL_DECAY_EN, DECAY_SHIFT=1 -> adder_potential=32'h40800000 at neuron 5.
REQ-031 Adder model asserts adder_spike for idx 7, spike_ready held 0 for 4 cycles -> spike_valid, spike_id=7 stable 5 cycles, scan resumes after transfer.
REQ-032 potential=32'h00800000 (e=1), DECAY_SHIFT=1 -> adder_potential=32'h0; potential=32'h7FC00000 -> unchanged.
REQ-033 reset asserted in EMIT for idx 2 -> spike_valid=0 next cycle, no done, all potentials 32'h0.
REQ-034 weight_valid during scan -> weight_ready=0, no array change; timestep_start during scan -> ignored, single done.
